// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the MEM stage and a debug/loader port; CPU grant and load are same-cycle.
// Denied CPU raises cpu_stall; debug wins after STARVE_LIMIT denied cycles or while locked; debug read data returns one cycle after ack.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [31:0]      dbg_addr,
  input  logic [31:0]      dbg_wdata,
  input  logic             dbg_lock,
  output logic             dbg_ack,
  output logic [31:0]      dbg_rdata,
  output logic             dbg_rvalid,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] stall_count
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;
  logic          lock_active;
  logic          starved;
  logic          dbg_gnt;
  logic          cpu_gnt;

  // Exactly one grant per cycle: debug only pre-empts a requesting CPU when locked or starved.
  always_comb begin
    starved = (starve_cnt >= LIMIT);
    dbg_gnt = dbg_req & ~reset & (~cpu_req | lock_active | starved);
    cpu_gnt = cpu_req & ~reset & ~dbg_gnt & ~lock_active;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rdata = mem_rdata;
  assign dbg_ack   = dbg_gnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt  <= '0;
      lock_active <= 1'b0;
      dbg_rdata   <= '0;
      dbg_rvalid  <= 1'b0;
      stall_count <= '0;
    end else begin
      if (dbg_gnt || !dbg_req) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
      // Lock is taken only on a debug grant and dropped the cycle after dbg_lock falls.
      lock_active <= dbg_lock & (lock_active | dbg_gnt);
      dbg_rvalid  <= dbg_gnt & ~dbg_we;
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata <= mem_rdata;
      end
      if (cpu_stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: an ownership model checked every cycle on the falling edge,
// plus directed scenarios with literal expectations.
module tb_dmem_port_arbiter;

  localparam int LIMIT  = 4;
  localparam int CW     = 4;
  localparam int SATMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset, cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0]   cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0]   cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic          cpu_stall, dbg_ack, dbg_rvalid, mem_we;
  logic [CW-1:0] stall_count;

  logic [31:0] env_mem [0:255];
  logic [31:0] ref_mem [0:255];

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          m_wait   = 0;
  bit          m_locked = 1'b0;
  bit          m_rvalid = 1'b0;
  logic [31:0] m_rdata  = 32'h0;
  int          m_stalls = 0;

  always #5 clock = ~clock;

  dmem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_count(stall_count)
  );

  // Environment memory: combinational read, write at the clock edge.
  assign mem_rdata = env_mem[mem_addr[9:2]];
  always @(posedge clock) if (mem_we) env_mem[mem_addr[9:2]] = mem_wdata;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: decide the port owner from priority rules, then advance the bookkeeping.
  always @(negedge clock) begin
    bit          d_win, c_win, c_stall, e_we;
    logic [31:0] e_addr, e_wdata;
    int          e_cnt;
    d_win = 1'b0;
    c_win = 1'b0;
    if (!reset) begin
      if (dbg_req && (m_locked || m_wait >= LIMIT)) d_win = 1'b1;
      else if (!m_locked) begin
        if (cpu_req) c_win = 1'b1;
        else if (dbg_req) d_win = 1'b1;
      end
    end
    c_stall = cpu_req && !c_win;
    e_we = 1'b0; e_addr = 32'h0; e_wdata = 32'h0;
    if (c_win) begin
      e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata;
    end else if (d_win) begin
      e_we = dbg_we; e_addr = dbg_addr; e_wdata = dbg_wdata;
    end
    e_cnt = (m_stalls > SATMAX) ? SATMAX : m_stalls;

    check("m_cpu_stall", cpu_stall, c_stall);
    check("m_dbg_ack", dbg_ack, d_win);
    check("m_mem_we", mem_we, e_we);
    check("m_mem_addr", mem_addr, e_addr);
    check("m_mem_wdata", mem_wdata, e_wdata);
    if (c_win && !cpu_we) check("m_cpu_rdata", cpu_rdata, ref_mem[cpu_addr[9:2]]);
    check("m_dbg_rvalid", dbg_rvalid, m_rvalid);
    check("m_dbg_rdata", dbg_rdata, m_rdata);
    check("m_stall_count", stall_count, e_cnt);

    if (reset) begin
      m_wait = 0; m_locked = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0; m_stalls = 0;
    end else begin
      m_wait = (dbg_req && !d_win) ? m_wait + 1 : 0;
      if (!dbg_lock) m_locked = 1'b0;
      else if (d_win) m_locked = 1'b1;
      m_rvalid = d_win && !dbg_we;
      if (m_rvalid) m_rdata = ref_mem[dbg_addr[9:2]];
      if (c_stall) m_stalls++;
      if (e_we) ref_mem[e_addr[9:2]] = e_wdata;
    end
  end

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit rst, input bit creq, input bit cwe, input logic [31:0] ca,
                       input logic [31:0] cw, input bit dreq, input bit dwe,
                       input logic [31:0] da, input logic [31:0] dw, input bit lk);
    reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cw;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = da; dbg_wdata = dw; dbg_lock = lk;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Leaves the bench at the start of the first cycle after reset.
  task automatic do_reset();
    nxt();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt();
    idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    env_mem[32'h40 >> 2] = 32'h1234;
    ref_mem[32'h40 >> 2] = 32'h1234;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset cycle with both requesting: no grants, CPU stalls, nothing counted.
    nxt();
    drive(1, 1, 1, 32'h40, 32'h99, 1, 1, 32'h80, 32'h77, 1);
    #2;
    check("rst_cpu_stall", cpu_stall, 1);
    check("rst_dbg_ack", dbg_ack, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_stall_count", stall_count, 0);

    // CPU only: load and store.
    nxt();
    drive(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    #2;
    check("cpu_rdata", cpu_rdata, 32'h1234);
    check("cpu_stall", cpu_stall, 0);
    check("cpu_stall_count", stall_count, 0);
    nxt();
    drive(0, 1, 1, 32'h44, 32'hA5A5, 0, 0, 0, 0, 0);
    #2;
    check("cpu_st_we", mem_we, 1);
    check("cpu_st_addr", mem_addr, 32'h44);

    // Debug only: write then read back.
    nxt();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h80, 32'hCAFEBABE, 0);
    #2;
    check("dbg_wr_ack", dbg_ack, 1);
    check("dbg_wr_wdata", mem_wdata, 32'hCAFEBABE);
    nxt();
    drive(0, 0, 0, 0, 0, 1, 0, 32'h80, 0, 0);
    #2;
    check("dbg_rd_ack", dbg_ack, 1);
    check("dbg_rd_rvalid_early", dbg_rvalid, 0);
    nxt();
    idle();
    #2;
    check("dbg_rvalid", dbg_rvalid, 1);
    check("dbg_rdata", dbg_rdata, 32'hCAFEBABE);
    nxt();
    #2;
    check("dbg_rvalid_pulse", dbg_rvalid, 0);
    check("dbg_rdata_hold", dbg_rdata, 32'hCAFEBABE);

    // Starvation: CPU wins cycles 0-3, debug on cycle 4, CPU again on 5.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) nxt();
      drive(0, 1, 0, 32'h40, 0, c < 5, 1, 32'h100, 32'(c), 0);
      #2;
      check("starve_stall", cpu_stall, c == 4);
      check("starve_ack", dbg_ack, c == 4);
    end
    check("starve_count", stall_count, 1);

    // Lock: grant on 4 via starvation with lock held, CPU locked out through cycle 7.
    do_reset();
    for (int c = 0; c < 11; c++) begin
      if (c > 0) nxt();
      if (c <= 4)      drive(0, 1, 0, 32'h40, 0, 1, 1, 32'h84, 32'h11, 1);
      else if (c <= 6) drive(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 1);
      else if (c <= 8) drive(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
      else             drive(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 1);
      #2;
      check("lock_stall", cpu_stall, (c >= 4 && c <= 7));
      check("lock_ack", dbg_ack, c == 4);
      if (c == 8) check("lock_count", stall_count, 4);
    end

    // Reset while locked with a read return in flight.
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 32'h80, 0, 1);
    #2;
    check("mr_ack0", dbg_ack, 1);
    nxt();
    drive(0, 1, 0, 32'h40, 0, 1, 0, 32'h44, 0, 1);
    #2;
    check("mr_ack1", dbg_ack, 1);
    check("mr_stall1", cpu_stall, 1);
    nxt();
    drive(1, 1, 0, 32'h40, 0, 0, 0, 0, 0, 1);
    #2;
    check("mr_rvalid_pre", dbg_rvalid, 1);
    check("mr_rdata_pre", dbg_rdata, 32'hA5A5);
    check("mr_count_pre", stall_count, 1);
    nxt();
    drive(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 1);
    #2;
    check("mr_rvalid", dbg_rvalid, 0);
    check("mr_rdata", dbg_rdata, 0);
    check("mr_count", stall_count, 0);
    check("mr_cpu_stall", cpu_stall, 0);
    check("mr_cpu_rdata", cpu_rdata, 32'h1234);

    // Saturation: lock the port, then stall the CPU for 20 cycles.
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1, 32'h88, 32'h22, 1);
    #2;
    check("sat_ack", dbg_ack, 1);
    for (int i = 0; i < 20; i++) begin
      nxt();
      drive(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 1);
    end
    nxt();
    #2;
    check("sat_count", stall_count, 15);
    nxt();
    #2;
    check("sat_count_hold", stall_count, 15);
    nxt();
    idle();

    // Mixed traffic checked by the model alone.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      nxt();
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            32'h40 + 32'($urandom_range(0, 3)) * 4, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            32'h80 + 32'($urandom_range(0, 3)) * 4, $urandom, $urandom_range(0, 3) == 0);
    end
    nxt();
    idle();
    nxt();
    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
